mem_burst_ddr_rr: RTL
=====================

Name: mem_burst_ddr_rr

Overview:
Parametrised successor to the single-port DDR burst bridge. It converts user write and read burst requests of arbitrary length into DDR IP local-interface transactions, split into chunks of up to BURST_SIZE beats. It arbitrates round-robin between simultaneous write and read requests and tracks read-data completion. It sits between the frame-buffer/ethernet FIFOs and the DDR controller IP core.

Parameters:
MEM_DATA_WIDTH, 32, local data width in bits; must be a multiple of 8.
ADDR_WIDTH, 25, local word address width.
LEN_WIDTH, 10, width of user burst length in beats.
SIZE_WIDTH, 3, width of LOCAL_SIZE.
BURST_SIZE, 2, maximum beats per local burst; legal range 1..2^SIZE_WIDTH-1.

Ports:
MEM_CLK  in  1  controller clock
RST_N  in  1  asynchronous active-low reset
WR_BURST_REQ  in  1  write request; held until WR_FINISH
WR_BURST_LEN  in  LEN_WIDTH  write beats
WR_BURST_ADDR  in  ADDR_WIDTH  write start word address
WR_BURST_DATA  in  MEM_DATA_WIDTH  show-ahead write word
WR_BURST_DATA_REQ  out  1  current write word consumed (pop)
RD_BURST_REQ  in  1  read request; held until RD_FINISH
RD_BURST_LEN  in  LEN_WIDTH  read beats
RD_BURST_ADDR  in  ADDR_WIDTH  read start word address
RD_BURST_DATA  out  MEM_DATA_WIDTH  read word (= LOCAL_RDATA)
RD_BURST_DATA_VALID  out  1  read word valid (= LOCAL_RDATA_VALID while reading)
WR_FINISH  out  1  one-cycle pulse: last write beat accepted
RD_FINISH  out  1  one-cycle pulse: last read beat returned
BURST_IDLE  out  1  idle and ready for a request
LOCAL_INITIAL_DONE  in  1  DDR calibration complete
RST_DDR_N  out  1  equals RST_N
LOCAL_READY  in  1  IP accepts command/beat
LOCAL_ADDR  out  ADDR_WIDTH  chunk start address
LOCAL_SIZE  out  SIZE_WIDTH  chunk beat count
LOCAL_BURSTBEGIN  out  1  first beat/command of chunk
LOCAL_WRITE_REQ  out  1  write beat valid
LOCAL_WDATA  out  MEM_DATA_WIDTH  = WR_BURST_DATA
LOCAL_BE  out  MEM_DATA_WIDTH/8  byte enables
LOCAL_READ_REQ  out  1  read command valid
LOCAL_RDATA  in  MEM_DATA_WIDTH  read data
LOCAL_RDATA_VALID  in  1  read data valid

Behaviour:
- Single clock MEM_CLK; reset is asynchronous and active-low on RST_N. Reset values: state IDLE; all strobes, LOCAL_ADDR, LOCAL_SIZE and counters 0; last_grant = READ, so WRITE wins the first tie.
- States: IDLE, WR_DATA, RD_CMD, RD_WAIT.
- IDLE:
  - Requests with LEN=0 are ignored.
  - Only WR valid -> WR_DATA. Only RD valid -> RD_CMD.
  - Both valid -> grant the opposite of last_grant, then update last_grant.
  - On grant, latch addr and len; remaining=len; LOCAL_SIZE=min(BURST_SIZE, len).
- WR_DATA:
  - LOCAL_WRITE_REQ=1. LOCAL_BURSTBEGIN=1 on the first beat of each chunk only; held until that beat is accepted.
  - A beat is accepted when LOCAL_WRITE_REQ && LOCAL_READY. WR_BURST_DATA_REQ equals that condition in the same cycle, so there are no over-pops.
  - After the last beat of a chunk: LOCAL_ADDR += LOCAL_SIZE, and LOCAL_SIZE=min(BURST_SIZE, remaining).
  - On the last beat of the burst: WR_FINISH pulse, -> IDLE.
- RD_CMD:
  - LOCAL_READ_REQ=LOCAL_BURSTBEGIN=1.
  - Each accepted command (LOCAL_READY=1): LOCAL_ADDR += LOCAL_SIZE, cmd_remaining -= LOCAL_SIZE, next LOCAL_SIZE=min(BURST_SIZE, cmd_remaining).
  - After the last command -> RD_WAIT.
- RD_WAIT, and also RD_CMD:
  - Count LOCAL_RDATA_VALID beats; data can return while commands are still issuing.
  - When count reaches len: RD_FINISH pulse, -> IDLE. This applies even if the last beat arrives in the same cycle the last command is accepted.
- LOCAL_RDATA_VALID outside RD_CMD/RD_WAIT is not forwarded and not counted.
- Address arithmetic is modulo 2^ADDR_WIDTH: wrap from all-ones to 0 is silent and allowed mid-burst.
- BURST_IDLE = (state==IDLE) && LOCAL_INITIAL_DONE && no valid request this cycle.
- LOCAL_INITIAL_DONE low: forced to IDLE, no grants. If it drops mid-burst: abort to IDLE next cycle, no FINISH pulse, all local strobes deasserted.
- User request lines sampled only in IDLE; changes mid-burst are ignored.

Optional Feature:
WR_BE_EN:
- Defined: adds input WR_BURST_BE (MEM_DATA_WIDTH/8 bits), show-ahead alongside WR_BURST_DATA; LOCAL_BE = WR_BURST_BE during write beats and all-ones during reads.
- Undefined: port absent, LOCAL_BE tied all-ones.

Test Plan:
- Write LEN=5, ADDR=0x100, BURST_SIZE=2, LOCAL_READY=1 -> chunks (0x100,2),(0x102,2),(0x104,1); 5 WR_BURST_DATA_REQ pulses; WR_FINISH on beat 5; LOCAL_BURSTBEGIN on beats 1,3,5.
- Read LEN=4, ADDR=0x200, ready toggling 1/0 -> commands (0x200,2),(0x202,2) held while ready=0; 4 valid beats returned 3 cycles late -> exactly one RD_FINISH on the 4th beat.
- WR and RD asserted together twice back-to-back -> grant order WR, RD, WR, RD; no beat interleaving.
- Write LEN=3 at ADDR=0x1FFFFFF -> LOCAL_ADDR sequence 0x1FFFFFF then 0x0000001; data beats intact.
- LOCAL_INITIAL_DONE dropped after 2 of 6 write beats -> IDLE next cycle, no WR_FINISH, LOCAL_WRITE_REQ=0; LEN=0 request -> no activity, BURST_IDLE stays 1.
- With WR_BE_EN: WR_BURST_BE=4'b0011 on beat 2 of LEN=2 -> LOCAL_BE=4'b0011 on that beat only.

Source files
------------

// File: rtl/mem_burst_ddr_rr.sv
// mem_burst_ddr_rr: round-robin write/read burst bridge onto a DDR local interface; define WR_BE_EN for user write byte enables
module mem_burst_ddr_rr #(
  parameter int MEM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 25,
  parameter int LEN_WIDTH      = 10,
  parameter int SIZE_WIDTH     = 3,
  parameter int BURST_SIZE     = 2
) (
  input  logic                        MEM_CLK,
  input  logic                        RST_N,
  input  logic                        WR_BURST_REQ,
  input  logic [LEN_WIDTH-1:0]        WR_BURST_LEN,
  input  logic [ADDR_WIDTH-1:0]       WR_BURST_ADDR,
  input  logic [MEM_DATA_WIDTH-1:0]   WR_BURST_DATA,
`ifdef WR_BE_EN
  input  logic [MEM_DATA_WIDTH/8-1:0] WR_BURST_BE,
`endif
  output logic                        WR_BURST_DATA_REQ,
  input  logic                        RD_BURST_REQ,
  input  logic [LEN_WIDTH-1:0]        RD_BURST_LEN,
  input  logic [ADDR_WIDTH-1:0]       RD_BURST_ADDR,
  output logic [MEM_DATA_WIDTH-1:0]   RD_BURST_DATA,
  output logic                        RD_BURST_DATA_VALID,
  output logic                        WR_FINISH,
  output logic                        RD_FINISH,
  output logic                        BURST_IDLE,
  input  logic                        LOCAL_INITIAL_DONE,
  output logic                        RST_DDR_N,
  input  logic                        LOCAL_READY,
  output logic [ADDR_WIDTH-1:0]       LOCAL_ADDR,
  output logic [SIZE_WIDTH-1:0]       LOCAL_SIZE,
  output logic                        LOCAL_BURSTBEGIN,
  output logic                        LOCAL_WRITE_REQ,
  output logic [MEM_DATA_WIDTH-1:0]   LOCAL_WDATA,
  output logic [MEM_DATA_WIDTH/8-1:0] LOCAL_BE,
  output logic                        LOCAL_READ_REQ,
  input  logic [MEM_DATA_WIDTH-1:0]   LOCAL_RDATA,
  input  logic                        LOCAL_RDATA_VALID
);
  typedef enum logic [1:0] {IDLE, WR_DATA, RD_CMD, RD_WAIT} state_t;
  state_t state_q, state_d;
  logic last_wr_q, last_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d, beat_q, beat_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d, len_q, len_d, cnt_q, cnt_d;
  logic wr_v, rd_v, gw, wr_st, rc_st, rd_st, wr_acc, rc_acc, rd_beat, rd_last, chunk_end;
  logic [LEN_WIDTH-1:0] req_len, cmd_rem;

  function automatic logic [SIZE_WIDTH-1:0] min_sz(input logic [LEN_WIDTH-1:0] n);
    return (n < LEN_WIDTH'(BURST_SIZE)) ? SIZE_WIDTH'(n) : SIZE_WIDTH'(BURST_SIZE);
  endfunction

  assign wr_v      = WR_BURST_REQ && (WR_BURST_LEN != '0);
  assign rd_v      = RD_BURST_REQ && (RD_BURST_LEN != '0);
  assign gw        = wr_v && (!rd_v || !last_wr_q);
  assign req_len   = gw ? WR_BURST_LEN : RD_BURST_LEN;
  // strobes drop in the same cycle calibration is lost, so nothing is accepted during the abort
  assign wr_st     = (state_q == WR_DATA) && LOCAL_INITIAL_DONE;
  assign rc_st     = (state_q == RD_CMD) && LOCAL_INITIAL_DONE;
  assign rd_st     = ((state_q == RD_CMD) || (state_q == RD_WAIT)) && LOCAL_INITIAL_DONE;
  assign wr_acc    = wr_st && LOCAL_READY;
  assign rc_acc    = rc_st && LOCAL_READY;
  assign rd_beat   = rd_st && LOCAL_RDATA_VALID;
  assign rd_last   = rd_beat && (cnt_q + LEN_WIDTH'(1) == len_q);
  assign chunk_end = (beat_q + SIZE_WIDTH'(1)) == size_q;
  assign cmd_rem   = rem_q - LEN_WIDTH'(size_q);

  assign WR_BURST_DATA_REQ   = wr_acc;
  assign WR_FINISH           = wr_acc && (rem_q == LEN_WIDTH'(1));
  assign RD_FINISH           = rd_last;
  assign RD_BURST_DATA       = LOCAL_RDATA;
  assign RD_BURST_DATA_VALID = rd_beat;
  assign BURST_IDLE          = (state_q == IDLE) && LOCAL_INITIAL_DONE && !wr_v && !rd_v;
  assign RST_DDR_N           = RST_N;
  assign LOCAL_ADDR          = addr_q;
  assign LOCAL_SIZE          = size_q;
  assign LOCAL_WRITE_REQ     = wr_st;
  assign LOCAL_READ_REQ      = rc_st;
  assign LOCAL_BURSTBEGIN    = rc_st || (wr_st && (beat_q == '0));
  assign LOCAL_WDATA         = WR_BURST_DATA;
`ifdef WR_BE_EN
  assign LOCAL_BE            = wr_st ? WR_BURST_BE : '1;
`else
  assign LOCAL_BE            = '1;
`endif

  // next state: grant in IDLE, step write beats, issue read commands and count returned beats
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    size_d    = size_q;
    beat_d    = beat_q;
    rem_d     = rem_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    if (!LOCAL_INITIAL_DONE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (wr_v || rd_v) begin
          state_d   = gw ? WR_DATA : RD_CMD;
          last_wr_d = (wr_v && rd_v) ? gw : last_wr_q;
          addr_d    = gw ? WR_BURST_ADDR : RD_BURST_ADDR;
          len_d     = req_len;
          rem_d     = req_len;
          size_d    = min_sz(req_len);
          beat_d    = '0;
          cnt_d     = '0;
        end
        WR_DATA: if (wr_acc) begin
          rem_d   = rem_q - LEN_WIDTH'(1);
          beat_d  = chunk_end ? '0 : beat_q + SIZE_WIDTH'(1);
          addr_d  = chunk_end ? addr_q + ADDR_WIDTH'(size_q) : addr_q;
          size_d  = chunk_end ? min_sz(rem_q - LEN_WIDTH'(1)) : size_q;
          state_d = (rem_q == LEN_WIDTH'(1)) ? IDLE : WR_DATA;
        end
        default: begin
          if (rc_acc) begin
            addr_d  = addr_q + ADDR_WIDTH'(size_q);
            rem_d   = cmd_rem;
            size_d  = min_sz(cmd_rem);
            state_d = (cmd_rem == '0) ? RD_WAIT : RD_CMD;
          end
          cnt_d   = rd_beat ? cnt_q + LEN_WIDTH'(1) : cnt_q;
          state_d = rd_last ? IDLE : state_d;
        end
      endcase
    end
  end

  // state and datapath registers; last grant starts as read so write wins the first tie
  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      beat_q    <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      beat_q    <= beat_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule
